// File: rtl/cv32e40p_fpu_arb_pkg.sv
// Shared types and helpers for the cluster FPU arbiter.
//   fpu_class_e : operation latency class (add/mul vs. others)
//   lat_of      : pipeline depth of a class given the two configured depths
//   max_lat     : larger of two depths, used to size the result-slot window
package cv32e40p_fpu_arb_pkg;

  typedef enum logic {
    FPU_CLASS_ADDMUL = 1'b0,
    FPU_CLASS_OTHERS = 1'b1
  } fpu_class_e;

  function automatic int unsigned lat_of(input fpu_class_e  cls,
                                         input int unsigned addmul_lat,
                                         input int unsigned others_lat);
    return (cls == FPU_CLASS_OTHERS) ? others_lat : addmul_lat;
  endfunction

  function automatic int unsigned max_lat(input int unsigned a,
                                          input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cv32e40p_rr_arb.sv
// Round-robin arbiter: picks the first requester at or after ptr_i,
// wrapping modulo N.
//   req_i   : request vector
//   ptr_i   : highest-priority index this cycle (must be < N)
//   gnt_o   : one-hot grant, zero when nothing requests
//   idx_o   : index of the granted requester, zero when idle
//   valid_o : any request present
module cv32e40p_rr_arb #(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  localparam int unsigned SW = IDX_W + 1;

  logic [N-1:0]     rot;
  logic [IDX_W-1:0] off;
  logic             found;
  logic [SW-1:0]    sum;

  always_comb begin
    // Rotate so the pointer position lands at bit 0; the first set bit is
    // then the offset of the winner from the pointer.
    rot   = N'({req_i, req_i} >> ptr_i);
    off   = '0;
    found = 1'b0;
    for (int unsigned j = 0; j < N; j++) begin
      if (!found && rot[j]) begin
        found = 1'b1;
        off   = IDX_W'(j);
      end
    end
    sum = {1'b0, ptr_i} + {1'b0, off};
    if (sum >= SW'(N)) sum = sum - SW'(N);
    valid_o = |req_i;
    idx_o   = valid_o ? sum[IDX_W-1:0] : '0;
    gnt_o   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      gnt_o[k] = valid_o && (idx_o == IDX_W'(k));
    end
  end

endmodule

// File: rtl/cv32e40p_fpu_arbiter.sv
// Shares one fixed-latency FPU between NUM_CORES cores. One op is issued per
// cycle, round-robin, and only when its writeback slot is free so results of
// the two latency classes never collide. A shadow tag pipeline routes each
// result back to the core that issued it.
//   clk_i, rst_i   : clock, async active-high reset
//   core_req_i     : per-core request
//   core_class_i   : per-core op class (0 addmul, 1 others)
//   core_gnt_o     : one-hot grant (same cycle as request)
//   core_rvalid_o  : one-hot result valid
//   fpu_req_o      : request to the FPU
//   fpu_class_o    : class of the selected op
//   fpu_id_o       : selected core (operand mux select)
//   fpu_gnt_i      : FPU accepts the request
//   fpu_rvalid_i   : FPU result valid
//   err_o          : sticky result-timing mismatch
module cv32e40p_fpu_arbiter
  import cv32e40p_fpu_arb_pkg::*;
#(
  parameter int unsigned  NUM_CORES  = 2,
  parameter int unsigned  ADDMUL_LAT = 0,
  parameter int unsigned  OTHERS_LAT = 0,
  localparam int unsigned ID_W       = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_CORES-1:0] core_req_i,
  input  logic [NUM_CORES-1:0] core_class_i,
  output logic [NUM_CORES-1:0] core_gnt_o,
  output logic [NUM_CORES-1:0] core_rvalid_o,
  output logic                 fpu_req_o,
  output logic                 fpu_class_o,
  output logic [ID_W-1:0]      fpu_id_o,
  input  logic                 fpu_gnt_i,
  input  logic                 fpu_rvalid_i,
  output logic                 err_o
);

  localparam int unsigned D        = max_lat(ADDMUL_LAT, OTHERS_LAT) + 1;
  localparam int unsigned SETTLE_W = $clog2(D + 1);

  logic [D-1:0]            res_q, res_d;
  logic [D-1:0][ID_W-1:0]  tag_q, tag_d;
  logic [NUM_CORES-1:0]    busy_q, busy_d;
  logic [ID_W-1:0]         ptr_q, ptr_d;
  logic                    err_q, err_d;
  logic [SETTLE_W-1:0]     settle_q, settle_d;

  logic [D:0]              res_ext;
  logic [D:0]              res_sh;
  logic [NUM_CORES-1:0]    rvalid;
  logic [NUM_CORES-1:0]    elig;
  logic [NUM_CORES-1:0]    arb_gnt;
  logic [ID_W-1:0]         sel_idx;
  logic                    sel_valid;
  logic                    issue;
  logic                    settling;
  int unsigned             sel_lat;

  // Extra zero on top so a slot index equal to D reads as free.
  assign res_ext = {1'b0, res_q};

  always_comb begin
    rvalid = '0;
    for (int unsigned k = 0; k < NUM_CORES; k++) begin
      rvalid[k] = fpu_rvalid_i & res_q[0] & (tag_q[0] == ID_W'(k));
    end
  end

  // A core whose result arrives this cycle may reissue immediately.
  always_comb begin
    elig   = '0;
    res_sh = '0;
    for (int unsigned k = 0; k < NUM_CORES; k++) begin
      res_sh  = res_ext >> (lat_of(fpu_class_e'(core_class_i[k]), ADDMUL_LAT, OTHERS_LAT) + 1);
      elig[k] = core_req_i[k] & (~busy_q[k] | rvalid[k]) & ~res_sh[0];
    end
    if (rst_i) elig = '0;
  end

  cv32e40p_rr_arb #(
    .N     (NUM_CORES),
    .IDX_W (ID_W)
  ) u_rr_arb (
    .req_i   (elig),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (sel_idx),
    .valid_o (sel_valid)
  );

  assign fpu_req_o     = sel_valid;
  assign fpu_id_o      = sel_idx;
  assign fpu_class_o   = sel_valid & core_class_i[sel_idx];
  assign sel_lat       = lat_of(fpu_class_e'(fpu_class_o), ADDMUL_LAT, OTHERS_LAT);
  assign issue         = sel_valid & fpu_gnt_i;
  assign core_gnt_o    = issue ? arb_gnt : '0;
  assign core_rvalid_o = rvalid;
  assign err_o         = err_q;

  // Results still in the FPU when reset hit have no slot; for D cycles after
  // release a stray fpu_rvalid_i is treated as one of those and ignored.
  assign settling = (settle_q != SETTLE_W'(D));

  always_comb begin
    res_d    = res_q >> 1;
    tag_d    = tag_q >> ID_W;
    ptr_d    = ptr_q;
    busy_d   = (busy_q & ~rvalid) | core_gnt_o;
    settle_d = settling ? settle_q + 1'b1 : settle_q;
    err_d    = err_q | ((fpu_rvalid_i != res_q[0]) & ~(settling & ~res_q[0]));
    if (issue) begin
      res_d = res_d | (D'(1) << sel_lat);
      for (int unsigned s = 0; s < D; s++) begin
        if (s == sel_lat) tag_d[s] = sel_idx;
      end
      ptr_d = (sel_idx == ID_W'(NUM_CORES - 1)) ? '0 : sel_idx + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      res_q    <= '0;
      tag_q    <= '0;
      busy_q   <= '0;
      ptr_q    <= '0;
      err_q    <= 1'b0;
      settle_q <= '0;
    end else begin
      res_q    <= res_d;
      tag_q    <= tag_d;
      busy_q   <= busy_d;
      ptr_q    <= ptr_d;
      err_q    <= err_d;
      settle_q <= settle_d;
    end
  end

endmodule
